// File: rtl/operand_select_stage.sv
// Operand select stage: resolves EX/MA forwarding and the immediate-for-B select, then
// buffers the operand bundle in a two-entry head/skid buffer toward the execute stage.
module operand_select_stage #(
    parameter int WIDTH    = 32,
    parameter int REG_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [REG_BITS-1:0] in_regA,
    input  logic [REG_BITS-1:0] in_regB,
    input  logic [WIDTH-1:0]    in_valA,
    input  logic [WIDTH-1:0]    in_valB,
    input  logic [WIDTH-1:0]    in_imm,
    input  logic                in_useImm,
    input  logic [7:0]          in_ac,
    input  logic [4:0]          in_pos,
    input  logic [4:0]          in_len,
    input  logic                ex_wrEn,
    input  logic [REG_BITS-1:0] ex_wrReg,
    input  logic [WIDTH-1:0]    ex_wrVal,
    input  logic                ex_ldPend,
    input  logic                ma_wrEn,
    input  logic [REG_BITS-1:0] ma_wrReg,
    input  logic [WIDTH-1:0]    ma_wrVal,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_valA,
    output logic [WIDTH-1:0]    out_valB,
    output logic [7:0]          out_ac,
    output logic [4:0]          out_pos,
    output logic [4:0]          out_len
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_out_valid;
    logic                r_in_ready;
    logic [WIDTH-1:0]    r_head_a;
    logic [WIDTH-1:0]    r_head_b;
    logic [7:0]          r_head_ac;
    logic [4:0]          r_head_pos;
    logic [4:0]          r_head_len;
    logic [WIDTH-1:0]    r_skid_a;
    logic [WIDTH-1:0]    r_skid_b;
    logic [7:0]          r_skid_ac;
    logic [4:0]          r_skid_pos;
    logic [4:0]          r_skid_len;

    logic [WIDTH-1:0]    w_fwd_a;
    logic [WIDTH-1:0]    w_fwd_b;
    logic                w_hz_a;
    logic                w_hz_b;
    logic                w_accept;
    logic                w_pop;

    // Register 0 is hard-wired, so it never matches a producer; EX is younger and wins over MA.
    function automatic logic [WIDTH-1:0] fwd_select(
        input logic [REG_BITS-1:0] src,
        input logic [WIDTH-1:0]    rf_val,
        input logic                ex_en,
        input logic [REG_BITS-1:0] ex_reg,
        input logic [WIDTH-1:0]    ex_val,
        input logic                ma_en,
        input logic [REG_BITS-1:0] ma_reg,
        input logic [WIDTH-1:0]    ma_val
    );
        logic [WIDTH-1:0] res;
        if ((src != {REG_BITS{1'b0}}) && ex_en && (ex_reg == src)) begin
            res = ex_val;
        end else if ((src != {REG_BITS{1'b0}}) && ma_en && (ma_reg == src)) begin
            res = ma_val;
        end else begin
            res = rf_val;
        end
        return res;
    endfunction

    // Operand resolution, load-use hazard detection and handshake qualification.
    always_comb begin
        w_fwd_a = fwd_select(in_regA, in_valA, ex_wrEn, ex_wrReg, ex_wrVal,
                             ma_wrEn, ma_wrReg, ma_wrVal);
        if (in_useImm) begin
            w_fwd_b = in_imm;
        end else begin
            w_fwd_b = fwd_select(in_regB, in_valB, ex_wrEn, ex_wrReg, ex_wrVal,
                                 ma_wrEn, ma_wrReg, ma_wrVal);
        end
        w_hz_a   = ex_wrEn && ex_ldPend && (in_regA != {REG_BITS{1'b0}}) && (ex_wrReg == in_regA);
        w_hz_b   = ex_wrEn && ex_ldPend && !in_useImm && (in_regB != {REG_BITS{1'b0}})
                   && (ex_wrReg == in_regB);
        w_accept = in_valid && r_in_ready && !(w_hz_a || w_hz_b) && !flush;
        w_pop    = r_out_valid && out_ready;
    end

    // Buffer control and data movement; handshake flags are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_head_a    <= {WIDTH{1'b0}};
            r_head_b    <= {WIDTH{1'b0}};
            r_head_ac   <= 8'd0;
            r_head_pos  <= 5'd0;
            r_head_len  <= 5'd0;
            r_skid_a    <= {WIDTH{1'b0}};
            r_skid_b    <= {WIDTH{1'b0}};
            r_skid_ac   <= 8'd0;
            r_skid_pos  <= 5'd0;
            r_skid_len  <= 5'd0;
        end else if (flush) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_head_a    <= w_fwd_a;
                        r_head_b    <= w_fwd_b;
                        r_head_ac   <= in_ac;
                        r_head_pos  <= in_pos;
                        r_head_len  <= in_len;
                        r_state     <= ST_ONE;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b1;
                    end else begin
                        r_state     <= ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_pop) begin
                        r_head_a    <= w_fwd_a;
                        r_head_b    <= w_fwd_b;
                        r_head_ac   <= in_ac;
                        r_head_pos  <= in_pos;
                        r_head_len  <= in_len;
                        r_state     <= ST_ONE;
                    end else if (w_accept) begin
                        r_skid_a    <= w_fwd_a;
                        r_skid_b    <= w_fwd_b;
                        r_skid_ac   <= in_ac;
                        r_skid_pos  <= in_pos;
                        r_skid_len  <= in_len;
                        r_state     <= ST_FULL;
                        r_in_ready  <= 1'b0;
                    end else if (w_pop) begin
                        r_state     <= ST_EMPTY;
                        r_out_valid <= 1'b0;
                    end else begin
                        r_state     <= ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        r_head_a    <= r_skid_a;
                        r_head_b    <= r_skid_b;
                        r_head_ac   <= r_skid_ac;
                        r_head_pos  <= r_skid_pos;
                        r_head_len  <= r_skid_len;
                        r_state     <= ST_ONE;
                        r_in_ready  <= 1'b1;
                    end else begin
                        r_state     <= ST_FULL;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_valA  = r_head_a;
    assign out_valB  = r_head_b;
    assign out_ac    = r_head_ac;
    assign out_pos   = r_head_pos;
    assign out_len   = r_head_len;

endmodule
